rf_multiport: RTL and testbench

Parametrised multi-port integer register file with an integrated pending-write scoreboard, the successor to the single-write, two-read pipeline register file. It sits in the decode/write-back boundary of the pipelined CPU. It provides NRD read ports with optional write-to-read bypass and NWR write ports with a defined priority. Per-register busy bits let decode detect RAW hazards against in-flight producers.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/rf_scoreboard.sv | 59 +++++
 rtl/rf_multiport.sv | 80 ++++++++
 tb/tb_rf_multiport.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers for slicing packed multi-port buses.
// Register-index validity lives here so every port applies the same rule.
package cpu_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   function automatic int data_lo(input int port, input int xlen);
      return port * xlen;
   endfunction

   function automatic int addr_lo(input int port, input int aw);
      return port * aw;
   endfunction

   // Nonzero and inside the array; x0 and out-of-range indices carry no state.
   function automatic logic addr_ok(input int a, input int nreg);
      return (a != 0) && (a < nreg);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared by write-back, wiped by flush.
module rf_scoreboard
   import cpu_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int AW     = $clog2(NREG),
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic              flush,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_busy
);

   logic [NREG-1:0] busy_d, busy_q;

   // Issue is applied after clears so a new producer supersedes the retiring one.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NWR; i++) begin
         if (wr_en[i] && addr_ok(int'(wr_addr[addr_lo(i, AW) +: AW]), NREG))
            busy_d[wr_addr[addr_lo(i, AW) +: AW]] = 1'b0;
      end
      if (iss_en && addr_ok(int'(iss_addr), NREG))
         busy_d[iss_addr] = 1'b1;
      if (flush)
         busy_d = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   always_comb begin
      rd_busy = '0;
      for (int j = 0; j < NRD; j++) begin
         if (addr_ok(int'(rd_addr[addr_lo(j, AW) +: AW]), NREG))
            rd_busy[j] = busy_q[rd_addr[addr_lo(j, AW) +: AW]];
         for (int i = 0; i < NWR; i++) begin
            if ((BYPASS != 0) && wr_en[i]
                && (wr_addr[addr_lo(i, AW) +: AW] == rd_addr[addr_lo(j, AW) +: AW]))
               rd_busy[j] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rf_multiport.sv
// Multi-port integer register file with prioritized writes, optional
// write-to-read forwarding and an integrated pending-write scoreboard.
module rf_multiport
   import cpu_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int AW     = $clog2(NREG),
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                flush
);

   logic [XLEN-1:0] rf_d [NREG];
   logic [XLEN-1:0] rf_q [NREG];

   // Ascending port order lets the highest-index writer land last and win.
   always_comb begin
      rf_d = rf_q;
      for (int i = 0; i < NWR; i++) begin
         if (wr_en[i] && addr_ok(int'(wr_addr[addr_lo(i, AW) +: AW]), NREG))
            rf_d[wr_addr[addr_lo(i, AW) +: AW]] = wr_data[data_lo(i, XLEN) +: XLEN];
      end
      rf_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int r = 0; r < NREG; r++)
            rf_q[r] <= '0;
      end else begin
         rf_q <= rf_d;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int j = 0; j < NRD; j++) begin
         if (addr_ok(int'(rd_addr[addr_lo(j, AW) +: AW]), NREG))
            rd_data[data_lo(j, XLEN) +: XLEN] = rf_q[rd_addr[addr_lo(j, AW) +: AW]];
         for (int i = 0; i < NWR; i++) begin
            if ((BYPASS != 0) && wr_en[i]
                && (wr_addr[addr_lo(i, AW) +: AW] == rd_addr[addr_lo(j, AW) +: AW])
                && addr_ok(int'(wr_addr[addr_lo(i, AW) +: AW]), NREG))
               rd_data[data_lo(j, XLEN) +: XLEN] = wr_data[data_lo(i, XLEN) +: XLEN];
         end
      end
   end

   rf_scoreboard #(
      .NREG   (NREG),
      .AW     (AW),
      .NRD    (NRD),
      .NWR    (NWR),
      .BYPASS (BYPASS)
   ) u_sb (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .flush    (flush),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy)
   );

endmodule

// File: tb/tb_rf_multiport.sv
// Random and directed bench for rf_multiport; a forwarding and a
// non-forwarding instance share stimulus and one array-based reference model.
module tb_rf_multiport;

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [9:0]  rd_addr;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic        flush;
   logic [63:0] rd_data_by, rd_data_nb;
   logic [1:0]  rd_busy_by, rd_busy_nb;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] m_rf   [32];
   logic        m_busy [32];

   always #5 clk = ~clk;

   rf_multiport #(.BYPASS(1)) dut_by (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data_by), .rd_busy(rd_busy_by),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush));

   rf_multiport #(.BYPASS(0)) dut_nb (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input int j, input bit byp);
      logic [4:0]  ra = rd_addr[j*5 +: 5];
      logic [31:0] r  = (ra == 0) ? 32'h0 : m_rf[ra];
      if (byp && ra != 0)
         for (int i = 0; i < 2; i++)
            if (wr_en[i] && wr_addr[i*5 +: 5] == ra) r = wr_data[i*32 +: 32];
      return r;
   endfunction

   function automatic logic exp_busy(input int j, input bit byp);
      logic [4:0] ra = rd_addr[j*5 +: 5];
      logic       b  = (ra == 0) ? 1'b0 : m_busy[ra];
      if (byp)
         for (int i = 0; i < 2; i++)
            if (wr_en[i] && wr_addr[i*5 +: 5] == ra) b = 1'b0;
      return b;
   endfunction

   task automatic settle();
      #1;
      for (int j = 0; j < 2; j++) begin
         chk($sformatf("by_data%0d", j), rd_data_by[j*32 +: 32], exp_data(j, 1'b1));
         chk($sformatf("nb_data%0d", j), rd_data_nb[j*32 +: 32], exp_data(j, 1'b0));
         chk($sformatf("by_busy%0d", j), {31'h0, rd_busy_by[j]}, {31'h0, exp_busy(j, 1'b1)});
         chk($sformatf("nb_busy%0d", j), {31'h0, rd_busy_nb[j]}, {31'h0, exp_busy(j, 1'b0)});
      end
   endtask

   // Advance one edge and apply the architectural rules to the model.
   task automatic tick();
      @(posedge clk);
      if (!rstn) begin
         for (int r = 0; r < 32; r++) begin m_rf[r] = 0; m_busy[r] = 0; end
      end else begin
         for (int i = 0; i < 2; i++)
            if (wr_en[i] && wr_addr[i*5 +: 5] != 0) begin
               m_rf[wr_addr[i*5 +: 5]]   = wr_data[i*32 +: 32];
               m_busy[wr_addr[i*5 +: 5]] = 1'b0;
            end
         if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
         if (flush) for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rstn = 1'b1; wr_en = 2'b00; iss_en = 1'b0; flush = 1'b0;
   endtask

   task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
      wr_en[p] = 1'b1; wr_addr[p*5 +: 5] = a; wr_data[p*32 +: 32] = d;
   endtask

   initial begin
      idle();
      rstn = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; iss_addr = '0;
      for (int r = 0; r < 32; r++) begin m_rf[r] = 'x; m_busy[r] = 'x; end
      @(negedge clk);
      tick();

      // Reset clears an earlier value.
      idle(); rd_addr = {5'd31, 5'd5};
      settle();
      chk("rst_x5", rd_data_nb[31:0], 32'h0);
      chk("rst_busy", {30'h0, rd_busy_nb}, 32'h0);
      wr(0, 5'd5, 32'hDEADBEEF); settle(); tick();
      idle(); settle();
      chk("x5_written", rd_data_nb[31:0], 32'hDEADBEEF);
      tick();
      rstn = 1'b0; settle(); tick();
      idle(); settle();
      chk("x5_after_rst", rd_data_nb[31:0], 32'h0);
      chk("x31_after_rst", rd_data_by[63:32], 32'h0);
      tick();

      // Same-address write collision; x0 write discarded.
      wr(0, 5'd7, 32'h11111111); wr(1, 5'd7, 32'h22222222);
      rd_addr = {5'd0, 5'd7}; settle(); tick();
      idle(); wr(0, 5'd0, 32'hFFFFFFFF); settle();
      chk("prio_x7", rd_data_nb[31:0], 32'h22222222);
      chk("x0_zero", rd_data_by[63:32], 32'h0);
      tick();

      // Forwarding versus registered read.
      idle(); wr(1, 5'd3, 32'hCAFEF00D); rd_addr = {5'd3, 5'd3}; settle();
      chk("byp_p0", rd_data_by[31:0], 32'hCAFEF00D);
      chk("byp_p1", rd_data_by[63:32], 32'hCAFEF00D);
      chk("nobyp_old", rd_data_nb[31:0], 32'h0);
      tick();
      idle(); settle();
      chk("nobyp_new", rd_data_nb[63:32], 32'hCAFEF00D);
      tick();

      // Scoreboard lifecycle.
      idle(); iss_en = 1'b1; iss_addr = 5'd9; rd_addr = {5'd9, 5'd9}; settle();
      chk("iss_not_same_cycle", {31'h0, rd_busy_by[0]}, 32'h0);
      tick();
      idle(); settle();
      chk("busy_x9", {31'h0, rd_busy_by[0]}, 32'h1);
      tick();
      wr(0, 5'd9, 32'h5); settle();
      chk("byp_clear_busy", {31'h0, rd_busy_by[1]}, 32'h0);
      chk("byp_clear_data", rd_data_by[63:32], 32'h5);
      chk("nobyp_still_busy", {31'h0, rd_busy_nb[1]}, 32'h1);
      tick();
      idle(); settle();
      chk("nobyp_cleared", {31'h0, rd_busy_nb[1]}, 32'h0);
      tick();

      // Set-and-clear race, then flush.
      idle(); iss_en = 1'b1; iss_addr = 5'd4; wr(0, 5'd4, 32'h44); rd_addr = {5'd4, 5'd4};
      settle(); tick();
      idle(); settle();
      chk("race_set_wins", {30'h0, rd_busy_nb}, 32'h3);
      tick();
      flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4; settle(); tick();
      idle(); settle();
      chk("flush_busy", {30'h0, rd_busy_by}, 32'h0);
      chk("flush_keeps_data", rd_data_nb[31:0], 32'h44);
      tick();

      // Reset mid-operation.
      idle(); iss_en = 1'b1; iss_addr = 5'd10; rd_addr = {5'd10, 5'd10}; settle(); tick();
      idle(); rstn = 1'b0; wr(0, 5'd10, 32'h99); settle(); tick();
      idle(); settle();
      chk("midrst_data", rd_data_by[31:0], 32'h0);
      chk("midrst_busy", {30'h0, rd_busy_by}, 32'h0);
      tick();

      // Random traffic over a small address window to provoke collisions.
      for (int c = 0; c < 800; c++) begin
         idle();
         rstn     = ($urandom_range(99) != 0);
         flush    = ($urandom_range(29) == 0);
         iss_en   = $urandom_range(1);
         iss_addr = 5'($urandom_range(c[0] ? 7 : 31));
         wr_en    = 2'($urandom_range(3));
         wr_addr  = {5'($urandom_range(7)), 5'($urandom_range(7))};
         wr_data  = {$urandom, $urandom};
         rd_addr  = {5'($urandom_range(7)), 5'($urandom_range(c[1] ? 7 : 31))};
         settle();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
